// File: rtl/fpu_uart_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_uart_sequencer_if
// Purpose  : Bundles the UART byte streams, the FPU operand/result handshake
//            and the status outputs of fpu_uart_sequencer.
// Modports : slave  - the sequencer (consumes rx/fpu results, drives tx/fpu)
//            master - the surrounding environment (UART PHY, FPU, monitor)
// Signals  : rx_data/rx_valid            received byte stream
//            tx_data/tx_start/tx_busy    transmit byte handshake
//            fpu_op/fpu_a/fpu_b/fpu_start FPU command
//            fpu_done/fpu_result         FPU response
//            busy/err_count              status
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_uart_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        busy;
  logic [7:0]  err_count;

  modport slave (
    input  rx_data, rx_valid, tx_busy, fpu_done, fpu_result,
    output tx_data, tx_start, fpu_op, fpu_a, fpu_b, fpu_start, busy, err_count
  );

  modport master (
    output rx_data, rx_valid, tx_busy, fpu_done, fpu_result,
    input  tx_data, tx_start, fpu_op, fpu_a, fpu_b, fpu_start, busy, err_count
  );
endinterface
`default_nettype wire

// File: rtl/fpu_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_uart_sequencer
// Purpose  : Receives a 9-byte command frame over UART (op byte, operand A
//            LSB first, operand B LSB first), runs it on an external FPU and
//            returns the 32-bit result as 4 bytes MSB first. Frame errors
//            (bad op byte, inter-byte timeout, FPU timeout, bytes arriving
//            while busy) are counted in a saturating 8-bit counter.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - fpu_uart_sequencer_if.slave (rx, tx, fpu, status)
// Params   : BYTE_TIMEOUT - idle clocks tolerated between frame bytes
//            FPU_TIMEOUT  - clocks allowed from fpu_start to fpu_done
// Revision : 1.0 - initial release
// ============================================================================
module fpu_uart_sequencer #(
  parameter int BYTE_TIMEOUT = 2_000_000,
  parameter int FPU_TIMEOUT  = 1024
) (
  input wire logic               clk,
  input wire logic               rst,
  fpu_uart_sequencer_if.slave    bus
);

  localparam int          BT_W    = $clog2(BYTE_TIMEOUT + 1);
  localparam int          FT_W    = $clog2(FPU_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FT_LAST = FT_W'(FPU_TIMEOUT - 1);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RX_A      = 3'd1,
    S_RX_B      = 3'd2,
    S_EXEC      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_TX_LOAD   = 3'd5,
    S_TX_WAIT   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [BT_W-1:0] btmr_q, btmr_d;
  logic [FT_W-1:0] ftmr_q, ftmr_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     res_q, res_d;
  logic [7:0]      err_q, err_d;
  logic            txw_first_q, txw_first_d;
  logic            err_evt;
  logic            tx_start_w;
  logic            fpu_start_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      btmr_q      <= '0;
      ftmr_q      <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      err_q       <= '0;
      txw_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      btmr_q      <= btmr_d;
      ftmr_q      <= ftmr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      err_q       <= err_d;
      txw_first_q <= txw_first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    btmr_d      = btmr_q;
    ftmr_d      = ftmr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    txw_first_d = txw_first_q;
    err_evt     = 1'b0;
    tx_start_w  = 1'b0;
    fpu_start_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        btmr_d = '0;
        if (bus.rx_valid) begin
          if (bus.rx_data[7:2] == 6'd0) begin
            op_d    = bus.rx_data[1:0];
            idx_d   = '0;
            state_d = S_RX_A;
          end else begin
            err_evt = 1'b1;
          end
        end
      end

      S_RX_A, S_RX_B: begin
        if (bus.rx_valid) begin
          btmr_d = '0;
          idx_d  = idx_q + 2'd1;
          if (state_q == S_RX_A) begin
            a_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
          end else begin
            b_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
          end
          // idx wraps to 0 after the 4th byte, ready for the next phase
          if (idx_q == 2'd3) begin
            state_d = (state_q == S_RX_A) ? S_RX_B : S_EXEC;
          end
        end else if (btmr_q == BT_LAST) begin
          err_evt = 1'b1;
          btmr_d  = '0;
          state_d = S_IDLE;
        end else begin
          btmr_d = btmr_q + 1'b1;
        end
      end

      S_EXEC: begin
        fpu_start_w = 1'b1;
        ftmr_d      = '0;
        state_d     = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // fpu_done takes priority over a coincident timeout expiry
        if (bus.fpu_done) begin
          res_d   = bus.fpu_result;
          idx_d   = '0;
          state_d = S_TX_LOAD;
        end else if (ftmr_q == FT_LAST) begin
          res_d   = QNAN;
          err_evt = 1'b1;
          idx_d   = '0;
          state_d = S_TX_LOAD;
        end else begin
          ftmr_d = ftmr_q + 1'b1;
        end
      end

      S_TX_LOAD: begin
        if (!bus.tx_busy) begin
          tx_start_w  = 1'b1;
          txw_first_d = 1'b1;
          state_d     = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        // The transmitter raises tx_busy only one cycle after tx_start, so
        // the first cycle here must not be mistaken for "byte finished".
        if (txw_first_q) begin
          txw_first_d = 1'b0;
        end else if (!bus.tx_busy) begin
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd3) ? S_IDLE : S_TX_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bytes arriving while a frame is being executed or returned are dropped
    if (bus.rx_valid && (state_q == S_EXEC || state_q == S_WAIT_DONE ||
                         state_q == S_TX_LOAD || state_q == S_TX_WAIT)) begin
      err_evt = 1'b1;
    end

    // Any number of error sources in one cycle counts once; saturate at FF
    err_d = (err_evt && (err_q != 8'hFF)) ? (err_q + 8'd1) : err_q;
  end

  // Result is returned MSB first: index 0 selects [31:24], 3 selects [7:0]
  assign bus.tx_data   = res_q[{~idx_q, 3'b000} +: 8];
  assign bus.tx_start  = tx_start_w;
  assign bus.fpu_start = fpu_start_w;
  assign bus.fpu_op    = op_q;
  assign bus.fpu_a     = a_q;
  assign bus.fpu_b     = b_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err_count = err_q;

endmodule
`default_nettype wire

// File: doc/fpu_uart_sequencer.md
FPU_UART_SEQUENCER -- requirements
Module: fpu_uart_sequencer

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 2_000_000, idle clocks allowed between received bytes of one frame (20 ms at 100 MHz).
REQ-002 Parameter FPU_TIMEOUT, default 1024, max clocks from fpu_start to fpu_done.
REQ-003 clk  in  1  single system clock, 100 MHz nominal, all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 rx_data  in  8  byte from UART receiver.
REQ-006 rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-007 tx_data  out  8  byte to UART transmitter.
REQ-008 tx_start  out  1  one-cycle pulse, transmitter loads tx_data.
REQ-009 tx_busy  in  1  transmitter busy; high from cycle after tx_start until byte (incl. stop bit) sent.
REQ-010 fpu_op  out  2  00 add, 01 mul, 10 div, 11 sub.
REQ-011 fpu_a, fpu_b  out  32  IEEE-754 single operands.
REQ-012 fpu_start  out  1  one-cycle pulse, operands/op stable from this cycle until fpu_done.
REQ-013 fpu_done  in  1  one-cycle pulse, fpu_result valid.
REQ-014 fpu_result  in  32  result word.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err_count  out  8  saturating count of frame errors.

Function
REQ-017 Frame in: 9 bytes -- op byte, A bytes LSB first, B bytes LSB first; frame out: 4 result bytes MSB first.
REQ-018 States: IDLE, RX_A, RX_B, EXEC, WAIT_DONE, TX_LOAD, TX_WAIT.
REQ-019 IDLE: on rx_valid with rx_data[7:2]==0, latch fpu_op=rx_data[1:0], clear byte index, go RX_A; rx_data[7:2]!=0 -> byte dropped, err_count+1, stay IDLE.
REQ-020 RX_A/RX_B: each rx_valid writes byte to lane index (0=[7:0]..3=[31:24]), index+1; after 4th byte RX_A->RX_B (index cleared), RX_B->EXEC.
REQ-021 Inter-byte counter clears on each accepted byte; reaching BYTE_TIMEOUT in RX_A/RX_B -> discard partial frame, err_count+1, IDLE.
REQ-022 EXEC: assert fpu_start exactly one cycle, go WAIT_DONE.
REQ-023 WAIT_DONE: fpu_done -> latch fpu_result into result register, go TX_LOAD; FPU_TIMEOUT cycles without fpu_done -> result register = 32'h7FC00000, err_count+1, go TX_LOAD.
REQ-024 TX_LOAD: when tx_busy==0, pulse tx_start with tx_data = result byte [31:24],[23:16],[15:8],[7:0] per index, go TX_WAIT.
REQ-025 TX_WAIT: ignore tx_busy in the cycle after tx_start; thereafter tx_busy==0 -> index+1, go TX_LOAD, or IDLE after 4th byte.
REQ-026 rx_valid in EXEC, WAIT_DONE, TX_LOAD, TX_WAIT: byte dropped, err_count+1; no frame realignment.
REQ-027 fpu_done outside WAIT_DONE ignored; fpu_done same cycle as timeout expiry -> fpu_done wins.
REQ-028 Latency: 9th rx_valid -> fpu_start 1 cycle later; fpu_done -> first tx_start 1 cycle later if tx_busy low.
REQ-029 err_count saturates at 8'hFF; simultaneous error sources in one cycle count once.
REQ-030 fpu_a, fpu_b, fpu_op hold last values outside a frame; they are not cleared on error.

Reset
REQ-031 On reset: state IDLE, indices and timers 0, tx_start=0, fpu_start=0, tx_data=0, fpu_op=0, fpu_a=0, fpu_b=0, result register 0, busy=0, err_count=0.
REQ-032 Reset mid-frame or mid-transmit aborts immediately; no further tx_start or fpu_start until a new frame completes.

Verification
REQ-033 Op 00, A=40600000, B=40000000, model returns 40B00000 -> fpu_a/fpu_b/fpu_op correct at fpu_start; tx bytes 40,B0,00,00 in order.
REQ-034 Op 02, A=3F800000, B=00000000, model returns 7F800000 -> tx bytes 7F,80,00,00, err_count unchanged.
REQ-035 Op byte then 3 bytes, silence > BYTE_TIMEOUT, then full op-01 frame (40000000 x 3FC00000) -> err_count=1, fpu_start once, result 40400000 sent.
REQ-036 Op byte 8'h05 -> dropped, err_count=1, busy stays 0; following valid frame processes normally.
REQ-037 Model never pulses fpu_done -> after FPU_TIMEOUT tx bytes 7F,C0,00,00, err_count=1.
REQ-038 Reset asserted during 2nd result byte -> tx_start low, busy=0, err_count=0 next cycle; next frame completes correctly.
